// File: rtl/ddr_init_refresh.sv
// DDR SDRAM power-up initialisation sequencer and auto-refresh scheduler.
// Owns CKE and the command bus during init, and takes the bus for refresh through a req/ack handshake.
module ddr_init_refresh #(
   parameter int                A_BITS     = 14,
   parameter int                BA_BITS    = 2,
   parameter int                T_INIT     = 10000,
   parameter int                T_RP       = 2,
   parameter int                T_MRD      = 2,
   parameter int                T_RFC      = 5,
   parameter int                T_DLL      = 200,
   parameter int                T_REFI     = 390,
   parameter int                N_INIT_REF = 2,
   parameter int                MAX_DEBT   = 8,
   parameter logic [A_BITS-1:0] MR         = A_BITS'(14'h0021),
   parameter logic [A_BITS-1:0] EMR        = A_BITS'(14'h0000)
) (
   input  logic               clock,
   input  logic               rst,
   output logic               cke,
   output logic [3:0]         cmd,
   output logic [A_BITS-1:0]  addr,
   output logic [BA_BITS-1:0] ba,
   output logic               init_done,
   output logic               ref_req,
   input  logic               ref_ack,
   output logic               ref_busy,
   output logic               ref_overrun
);

   localparam int CW = $clog2(T_INIT + T_DLL + T_REFI + T_RFC + T_RP + T_MRD + 1);
   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t INIT_LAST = cnt_t'(T_INIT - 1);
   localparam cnt_t RP_LAST   = cnt_t'(T_RP - 1);
   localparam cnt_t MRD_LAST  = cnt_t'(T_MRD - 1);
   localparam cnt_t RFC_LAST  = cnt_t'(T_RFC - 1);
   localparam cnt_t DLL_LAST  = cnt_t'(T_DLL - 1);
   localparam cnt_t REFI_LAST = cnt_t'(T_REFI - 1);
   localparam logic [3:0] IREF_LAST = 4'(N_INIT_REF - 1);
   localparam logic [3:0] DEBT_MAX  = 4'(MAX_DEBT);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   localparam logic [A_BITS-1:0]  ADDR_ZERO = {A_BITS{1'b0}};
   localparam logic [A_BITS-1:0]  ADDR_PRE  = A_BITS'(32'h0000_0400);
   localparam logic [A_BITS-1:0]  MR_DLL    = MR | A_BITS'(32'h0000_0100);
   localparam logic [BA_BITS-1:0] BA_ZERO   = {BA_BITS{1'b0}};
   localparam logic [BA_BITS-1:0] BA_EMR    = BA_BITS'(2'b01);

   typedef enum logic [3:0] {
      S_PWR     = 4'd0,
      S_CKE     = 4'd1,
      S_PRE1    = 4'd2,
      S_EMRS    = 4'd3,
      S_MRS_DLL = 4'd4,
      S_PRE2    = 4'd5,
      S_IREF    = 4'd6,
      S_MRS     = 4'd7,
      S_DLLW    = 4'd8,
      S_IDLE    = 4'd9,
      S_RPRE    = 4'd10,
      S_RREF    = 4'd11
   } state_t;

   state_t     state_r;
   cnt_t       wait_cnt_r;
   cnt_t       dll_cnt_r;
   cnt_t       refi_cnt_r;
   logic [3:0] iref_cnt_r;
   logic [3:0] debt_r;

   logic       tick_s;
   logic       dec_s;
   logic [3:0] debt_next_s;

   // Refresh debt bookkeeping: a tick and a REF issued on the same edge cancel out.
   always_comb begin
      dec_s       = 1'b0;
      tick_s      = 1'b0;
      debt_next_s = debt_r;
      case (state_r)
         S_RPRE:  dec_s = (wait_cnt_r == RP_LAST);
         S_RREF:  dec_s = (wait_cnt_r == RFC_LAST) && (debt_r != 4'd0);
         default: dec_s = 1'b0;
      endcase
      tick_s = init_done && (refi_cnt_r == REFI_LAST);
      if (tick_s && !dec_s) begin
         if (debt_r == DEBT_MAX) begin
            debt_next_s = debt_r;
         end else begin
            debt_next_s = debt_r + 4'd1;
         end
      end else if (dec_s && !tick_s) begin
         debt_next_s = debt_r - 4'd1;
      end else begin
         debt_next_s = debt_r;
      end
   end

   // Init/refresh FSM with registered command bus, counters and status flags.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_r     <= S_PWR;
         cke         <= 1'b0;
         cmd         <= CMD_NOP;
         addr        <= ADDR_ZERO;
         ba          <= BA_ZERO;
         init_done   <= 1'b0;
         ref_req     <= 1'b0;
         ref_busy    <= 1'b0;
         ref_overrun <= 1'b0;
         debt_r      <= 4'd0;
         refi_cnt_r  <= cnt_t'(0);
         wait_cnt_r  <= cnt_t'(0);
         dll_cnt_r   <= cnt_t'(0);
         iref_cnt_r  <= 4'd0;
      end else begin
         cmd     <= CMD_NOP;
         addr    <= ADDR_ZERO;
         ba      <= BA_ZERO;
         ref_req <= 1'b0;
         debt_r  <= debt_next_s;

         if (tick_s) begin
            refi_cnt_r <= cnt_t'(0);
         end else if (init_done) begin
            refi_cnt_r <= refi_cnt_r + cnt_t'(1);
         end
         if (tick_s && (debt_r == DEBT_MAX)) begin
            ref_overrun <= 1'b1;
         end
         // Counts from the DLL-reset MRS; saturation keeps the DLL wait check a simple compare.
         if (dll_cnt_r != DLL_LAST) begin
            dll_cnt_r <= dll_cnt_r + cnt_t'(1);
         end

         case (state_r)
            S_PWR: begin
               if (wait_cnt_r == INIT_LAST) begin
                  state_r    <= S_CKE;
                  cke        <= 1'b1;
                  wait_cnt_r <= cnt_t'(0);
               end else begin
                  wait_cnt_r <= wait_cnt_r + cnt_t'(1);
               end
            end
            S_CKE: begin
               state_r    <= S_PRE1;
               cmd        <= CMD_PRE;
               addr       <= ADDR_PRE;
               wait_cnt_r <= cnt_t'(0);
            end
            S_PRE1: begin
               if (wait_cnt_r == RP_LAST) begin
                  state_r    <= S_EMRS;
                  cmd        <= CMD_MRS;
                  ba         <= BA_EMR;
                  addr       <= EMR;
                  wait_cnt_r <= cnt_t'(0);
               end else begin
                  wait_cnt_r <= wait_cnt_r + cnt_t'(1);
               end
            end
            S_EMRS: begin
               if (wait_cnt_r == MRD_LAST) begin
                  state_r    <= S_MRS_DLL;
                  cmd        <= CMD_MRS;
                  addr       <= MR_DLL;
                  wait_cnt_r <= cnt_t'(0);
                  dll_cnt_r  <= cnt_t'(0);
               end else begin
                  wait_cnt_r <= wait_cnt_r + cnt_t'(1);
               end
            end
            S_MRS_DLL: begin
               if (wait_cnt_r == MRD_LAST) begin
                  state_r    <= S_PRE2;
                  cmd        <= CMD_PRE;
                  addr       <= ADDR_PRE;
                  wait_cnt_r <= cnt_t'(0);
               end else begin
                  wait_cnt_r <= wait_cnt_r + cnt_t'(1);
               end
            end
            S_PRE2: begin
               if (wait_cnt_r == RP_LAST) begin
                  state_r    <= S_IREF;
                  cmd        <= CMD_REF;
                  iref_cnt_r <= 4'd0;
                  wait_cnt_r <= cnt_t'(0);
               end else begin
                  wait_cnt_r <= wait_cnt_r + cnt_t'(1);
               end
            end
            S_IREF: begin
               if (wait_cnt_r == RFC_LAST) begin
                  wait_cnt_r <= cnt_t'(0);
                  if (iref_cnt_r == IREF_LAST) begin
                     state_r <= S_MRS;
                     cmd     <= CMD_MRS;
                     addr    <= MR;
                  end else begin
                     iref_cnt_r <= iref_cnt_r + 4'd1;
                     cmd        <= CMD_REF;
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r + cnt_t'(1);
               end
            end
            S_MRS: begin
               if (wait_cnt_r == MRD_LAST) begin
                  state_r    <= S_DLLW;
                  wait_cnt_r <= cnt_t'(0);
               end else begin
                  wait_cnt_r <= wait_cnt_r + cnt_t'(1);
               end
            end
            S_DLLW: begin
               if (dll_cnt_r == DLL_LAST) begin
                  state_r   <= S_IDLE;
                  init_done <= 1'b1;
                  ref_req   <= (debt_next_s != 4'd0);
               end else begin
                  state_r <= S_DLLW;
               end
            end
            S_IDLE: begin
               if (ref_req && ref_ack) begin
                  state_r    <= S_RPRE;
                  ref_busy   <= 1'b1;
                  cmd        <= CMD_PRE;
                  addr       <= ADDR_PRE;
                  wait_cnt_r <= cnt_t'(0);
               end else begin
                  ref_req <= (debt_next_s != 4'd0);
               end
            end
            S_RPRE: begin
               if (wait_cnt_r == RP_LAST) begin
                  state_r    <= S_RREF;
                  cmd        <= CMD_REF;
                  wait_cnt_r <= cnt_t'(0);
               end else begin
                  wait_cnt_r <= wait_cnt_r + cnt_t'(1);
               end
            end
            S_RREF: begin
               if (wait_cnt_r == RFC_LAST) begin
                  wait_cnt_r <= cnt_t'(0);
                  // Banks are still closed, so back-to-back refreshes skip the PRE.
                  if (debt_r != 4'd0) begin
                     cmd <= CMD_REF;
                  end else begin
                     state_r  <= S_IDLE;
                     ref_busy <= 1'b0;
                     ref_req  <= (debt_next_s != 4'd0);
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r + cnt_t'(1);
               end
            end
            default: begin
               state_r    <= S_PWR;
               cke        <= 1'b0;
               init_done  <= 1'b0;
               ref_busy   <= 1'b0;
               wait_cnt_r <= cnt_t'(0);
            end
         endcase
      end
   end

endmodule

// File: doc/ddr_init_refresh.md
Name: ddr_init_refresh

Overview:
- Parametrised DDR SDRAM power-up initialisation sequencer and auto-refresh scheduler for the board-level memory path (BeMicroSDK-class 16-bit DDR).
- Drives CKE and the command/address bus during init and refresh.
- Arbitrates refresh against the main DDR controller with a req/ack handshake and keeps a bounded refresh-debt counter.
- All timings are cycle-count parameters, so one block serves any board clock.

Parameters:
- A_BITS, 14, row/column address width.
- BA_BITS, 2, bank address width.
- T_INIT, 10000, power-up wait with CKE low, in cycles (200 us at 50 MHz).
- T_RP, 2, precharge-to-command cycles.
- T_MRD, 2, mode-register-set-to-command cycles.
- T_RFC, 5, refresh-to-command cycles.
- T_DLL, 200, cycles after DLL-reset MRS before init_done.
- T_REFI, 390, average refresh interval in cycles.
- N_INIT_REF, 2, auto-refreshes in the init sequence (range 2..15).
- MAX_DEBT, 8, refresh debt saturation (range 1..15).
- MR, 14'h0021, base mode register value: BL2, CL2, sequential.
- EMR, 14'h0000, extended mode register value: DLL enabled, full drive.

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous active-high reset
- cke  out  1  SDRAM clock enable
- cmd  out  4  {cs_n,ras_n,cas_n,we_n}
- addr  out  A_BITS  SDRAM address
- ba  out  BA_BITS  bank address
- init_done  out  1  init complete; sticky until rst
- ref_req  out  1  refresh wanted; controller must close rows, then ack
- ref_ack  in  1  controller idle, all banks precharged; bus granted
- ref_busy  out  1  block owns command bus (controller must mux in its own cmd only when init_done && !ref_busy)
- ref_overrun  out  1  sticky: interval tick arrived while debt == MAX_DEBT

Behaviour:
- Encodings: NOP 0111, PRE 0010, REF 0001, MRS 0000.
- PRE-all: addr[10]=1, all other addr bits 0.
- In every non-command cycle: cmd=NOP, addr=0, ba=0.
- Reset (rst sampled high):
  - state=S_PWR, cke=0, cmd=NOP, addr=0, ba=0.
  - init_done=0, ref_req=0, ref_busy=0, ref_overrun=0.
  - debt=0, interval counter=0, wait counter=0.
  - Reset mid-sequence or mid-refresh aborts immediately to these values.
- Every command is one cycle; the following wait is exactly the named parameter in cycles, including the command cycle; NOP is driven for the remaining cycles.
- Init FSM:
  - S_PWR: cke=0 for T_INIT cycles.
  - S_CKE: cke=1, one NOP cycle.
  - S_PRE1: PRE-all, wait T_RP.
  - S_EMRS: MRS ba=01 addr=EMR, wait T_MRD.
  - S_MRS_DLL: MRS ba=00 addr=MR|14'h0100, wait T_MRD.
  - S_PRE2: PRE-all, wait T_RP.
  - S_IREF: REF repeated N_INIT_REF times, each followed by a T_RFC wait.
  - S_MRS: MRS ba=00 addr=MR, wait T_MRD.
  - S_DLLW: wait until T_DLL cycles have elapsed since the S_MRS_DLL command cycle (never less than 1 cycle).
  - S_IDLE: entered with init_done=1 in the same cycle.
- cke stays 1 from S_CKE onwards until rst.
- Interval counter:
  - Runs only when init_done=1.
  - Counts 0..T_REFI-1; wrap is a tick.
  - Tick: debt+1, saturating at MAX_DEBT. A tick at saturation sets ref_overrun.
  - Tick in the same cycle as a debt decrement: debt unchanged.
- ref_req = (state==S_IDLE) && debt!=0, registered; deasserts the cycle after ack is accepted.
- Refresh FSM:
  - S_IDLE with ref_req && ref_ack sampled high → S_RPRE.
  - S_RPRE: ref_busy=1 from this cycle; PRE-all, wait T_RP.
  - S_RREF: REF; debt decremented in this command cycle; wait T_RFC.
  - If debt still !=0 after the wait: go to S_RREF again, skipping the PRE since banks are already closed.
  - Else → S_IDLE with ref_busy=0.
- ref_ack while ref_req=0 is ignored.
- ref_ack during init is ignored.
- ref_busy is 0 throughout init; the controller keys off init_done for init ownership.

Test Plan:
- Init sequence (T_INIT=20, T_RP=2, T_MRD=2, T_RFC=5, T_DLL=30, N_INIT_REF=2), release rst at cycle 0:
  - cke rises at cycle 20.
  - Command order: PRE(addr 0x400) → MRS ba=1 addr 0 → MRS ba=0 addr 0x121 → PRE → REF → REF → MRS ba=0 addr 0x021.
  - Spacing between commands exactly per parameters.
  - init_done rises exactly 30 cycles after the DLL-reset MRS.
- Single refresh (T_REFI=50), ref_ack tied high:
  - ref_req rises ≤1 cycle after the tick.
  - PRE then REF 2 cycles later.
  - ref_busy high for T_RP+T_RFC=7 cycles.
  - Debt returns to 0.
- Debt burst, ref_ack held low for 3 ticks:
  - ref_req stays high while debt reaches 3.
  - On ack: exactly 1 PRE followed by 3 REFs spaced 5 cycles; then ref_busy=0.
- Overrun, MAX_DEBT=2, ack held low for 3 ticks:
  - debt saturates at 2.
  - ref_overrun=1 from the third tick and stays 1 after the refreshes complete.
- Tick coincident with the REF command cycle while debt=1:
  - debt stays 1.
  - A second REF follows without PRE.
- rst pulsed mid-refresh (during the T_RFC wait):
  - Next cycle: cke=0, cmd=NOP, init_done=0, ref_busy=0, ref_overrun=0.
  - Full init sequence repeats.
